// File: rtl/key_event_controller.sv
// rtl/key_event_controller.sv - debounced key press/repeat/release events on a valid/ready stream
module key_event_controller #(
  parameter int NUM_KEYS     = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int SAMPLE_DIV   = 50000,
  parameter int STABLE_COUNT = 10,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  localparam int KEY_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] keySync,
  output logic [NUM_KEYS-1:0] keyState,
  output logic                eventValid,
  input  logic                eventReady,
  output logic [KEY_W-1:0]    eventKey,
  output logic [1:0]          eventType,
  output logic                eventDropped
);
  localparam int DIV_W   = $clog2(SAMPLE_DIV);
  localparam int CNT_W   = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
  localparam logic [RPT_W-1:0] RPT_DLY  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PER  = RPT_W'(REPEAT_RATE);
  localparam logic [1:0] T_PRESS   = 2'b01;
  localparam logic [1:0] T_REPEAT  = 2'b11;
  localparam logic [1:0] T_RELEASE = 2'b10;
  localparam logic AL = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]                div_q, div_d;
  logic                            tick;
  logic [NUM_KEYS-1:0]             raw;
  logic [NUM_KEYS-1:0]             state_q, state_d;
  logic [NUM_KEYS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_KEYS-1:0][RPT_W-1:0]  rpt_q, rpt_d;
  logic [NUM_KEYS-1:0]             rep_q, rep_d;
  logic [NUM_KEYS-1:0]             ev_press, ev_rpt, ev_rel;
  logic [NUM_KEYS-1:0]             pend_p_q, pend_p_d, pend_r_q, pend_r_d, pend_l_q, pend_l_d;
  logic [NUM_KEYS-1:0]             pend_any, gp, gr, gl;
  logic                            valid_q, valid_d, drop_q, drop_d, load, gnt_any;
  logic [KEY_W-1:0]                key_q, key_d, ptr_q, ptr_d, gnt_idx, scan_idx;
  logic [1:0]                      type_q, type_d, gnt_type;
  int                              scan;

  always_comb begin
    raw      = keySync ^ {NUM_KEYS{AL}};
    tick     = (div_q == DIV_LAST);
    div_d    = tick ? '0 : div_q + 1'b1;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rpt_d    = rpt_q;
    rep_d    = rep_q;
    ev_press = '0;
    ev_rpt   = '0;
    ev_rel   = '0;
    if (tick) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (raw[i] != state_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            state_d[i]  = raw[i];
            cnt_d[i]    = '0;
            rpt_d[i]    = '0;
            rep_d[i]    = 1'b0;
            ev_press[i] = raw[i];
            ev_rel[i]   = !raw[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
          // repeat timing only advances while the key is stably held, so a pending release never repeats
          if (state_q[i]) begin
            if (rpt_q[i] + 1'b1 == (rep_q[i] ? RPT_PER : RPT_DLY)) begin
              rpt_d[i]  = '0;
              rep_d[i]  = 1'b1;
              ev_rpt[i] = 1'b1;
            end else begin
              rpt_d[i] = rpt_q[i] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    pend_any = pend_p_q | pend_r_q | pend_l_q;
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_type = T_RELEASE;
    scan     = 0;
    scan_idx = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      scan = int'(ptr_q) + 1 + k;
      if (scan >= NUM_KEYS) scan = scan - NUM_KEYS;
      scan_idx = KEY_W'(scan);
      if (!gnt_any && pend_any[scan_idx]) begin
        gnt_any  = 1'b1;
        gnt_idx  = scan_idx;
        gnt_type = pend_p_q[scan_idx] ? T_PRESS : (pend_r_q[scan_idx] ? T_REPEAT : T_RELEASE);
      end
    end
  end

  always_comb begin
    load = !valid_q || eventReady;
    gp   = '0;
    gr   = '0;
    gl   = '0;
    if (load && gnt_any) begin
      case (gnt_type)
        T_PRESS:  gp[gnt_idx] = 1'b1;
        T_REPEAT: gr[gnt_idx] = 1'b1;
        default:  gl[gnt_idx] = 1'b1;
      endcase
    end
    pend_p_d = (pend_p_q & ~gp) | ev_press;
    pend_r_d = ((pend_r_q & ~gr) | ev_rpt) & ~ev_rel;
    pend_l_d = (pend_l_q & ~gl) | ev_rel;
    drop_d   = |((ev_press & pend_p_q & ~gp) | (ev_rpt & pend_r_q & ~gr) | (ev_rel & pend_l_q & ~gl));
    valid_d  = valid_q;
    key_d    = key_q;
    type_d   = type_q;
    ptr_d    = ptr_q;
    if (load) begin
      valid_d = gnt_any;
      if (gnt_any) begin
        key_d  = gnt_idx;
        type_d = gnt_type;
        ptr_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      div_q    <= '0;
      state_q  <= '0;
      cnt_q    <= '0;
      rpt_q    <= '0;
      rep_q    <= '0;
      pend_p_q <= '0;
      pend_r_q <= '0;
      pend_l_q <= '0;
      valid_q  <= 1'b0;
      key_q    <= '0;
      type_q   <= '0;
      drop_q   <= 1'b0;
      ptr_q    <= '0;
    end else begin
      div_q    <= div_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rpt_q    <= rpt_d;
      rep_q    <= rep_d;
      pend_p_q <= pend_p_d;
      pend_r_q <= pend_r_d;
      pend_l_q <= pend_l_d;
      valid_q  <= valid_d;
      key_q    <= key_d;
      type_q   <= type_d;
      drop_q   <= drop_d;
      ptr_q    <= ptr_d;
    end
  end

  assign keyState     = state_q;
  assign eventValid   = valid_q;
  assign eventKey     = key_q;
  assign eventType    = type_q;
  assign eventDropped = drop_q;

endmodule

// File: tb/tb_key_event_controller.sv
// tb/tb_key_event_controller.sv - directed scoreboard bench for key_event_controller
module tb_key_event_controller;
  logic       clock;
  logic       resetn;
  logic [3:0] keySync;
  logic [3:0] keyState;
  logic       eventValid;
  logic       eventReady;
  logic [1:0] eventKey;
  logic [1:0] eventType;
  logic       eventDropped;

  typedef struct { int key; int typ; int cyc; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int t, t0, a, drop0;

  key_event_controller #(
    .NUM_KEYS(4), .ACTIVE_LOW(1), .SAMPLE_DIV(4),
    .STABLE_COUNT(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .clock(clock), .resetn(resetn), .keySync(keySync), .keyState(keyState),
    .eventValid(eventValid), .eventReady(eventReady), .eventKey(eventKey),
    .eventType(eventType), .eventDropped(eventDropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic void push(input int k, input int ty, input int c);
    sb.push_back('{k, ty, c});
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // accepted events are popped against the expected stream, including the cycle they appear in
  always @(negedge clock) begin
    if (resetn) begin
      if (eventDropped) drop_cnt++;
      if (eventValid && eventReady) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_event: observed key=%0d type=%0b cyc=%0d expected no event", eventKey, eventType, cyc);
        end
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("ev_key", 32'(eventKey), mon_e.key);
          chk("ev_type", 32'(eventType), mon_e.typ);
          chk("ev_cyc", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    keySync = 4'b1111;
    eventReady = 1'b1;
    step(3);
    chk("rst_state", 32'(keyState), 0);
    chk("rst_valid", 32'(eventValid), 0);
    chk("rst_key", 32'(eventKey), 0);
    chk("rst_type", 32'(eventType), 0);
    chk("rst_drop", 32'(eventDropped), 0);
    resetn = 1'b1;
    step(4);

    // press and release of key 2
    t = cyc; keySync[2] = 1'b0; push(2, 1, t + 13);
    step(11); chk("t1_state_pre", 32'(keyState), 32'b0000);
    step(1);  chk("t1_state_on", 32'(keyState), 32'b0100);
    step(4);  t = cyc; keySync[2] = 1'b1; push(2, 2, t + 13);
    step(12); chk("t1_state_off", 32'(keyState), 0);
    step(4);  chk("t1_drained", sb.size(), 0);

    // short glitch on key 1
    keySync[1] = 1'b0;
    step(8);  keySync[1] = 1'b1; chk("t2_state_mid", 32'(keyState), 0);
    step(16); chk("t2_state_end", 32'(keyState), 0);
    chk("t2_valid", 32'(eventValid), 0);

    // key 0 held: repeats at ticks 5, 7, 9, 11 after acceptance
    t = cyc; a = t + 12; keySync[0] = 1'b0;
    push(0, 1, a + 1); push(0, 3, a + 21); push(0, 3, a + 29); push(0, 3, a + 37); push(0, 3, a + 45);
    step(60); keySync[0] = 1'b1; push(0, 2, a + 61);
    step(12); chk("t3_state_off", 32'(keyState), 0);
    step(4);  chk("t3_drained", sb.size(), 0);

    // tap key 3 so the round-robin pointer sits on key 3
    t = cyc; keySync[3] = 1'b0; push(3, 1, t + 13);
    step(16); keySync[3] = 1'b1; push(3, 2, t + 29);
    step(16); chk("tap3_drained", sb.size(), 0);

    // keys 0, 1, 3 together with the consumer stalled
    t = cyc; eventReady = 1'b0; keySync = 4'b0100;
    step(13);
    chk("t4_valid", 32'(eventValid), 1);
    chk("t4_key", 32'(eventKey), 0);
    chk("t4_type", 32'(eventType), 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t4_hold_valid", 32'(eventValid), 1);
      chk("t4_hold_key", 32'(eventKey), 0);
      chk("t4_hold_type", 32'(eventType), 1);
    end
    push(0, 1, t + 23); push(1, 1, t + 24); push(3, 1, t + 25);
    eventReady = 1'b1;
    step(3);  chk("t4_valid_low", 32'(eventValid), 0);
    step(2);  keySync = 4'b1111;
    push(0, 2, t + 41); push(1, 2, t + 42); push(3, 2, t + 43);
    step(20); chk("t4_drained", sb.size(), 0);
    chk("t4_state_off", 32'(keyState), 0);

    // key 2 press/release/press while stalled behind a key 1 press
    t = cyc; drop0 = drop_cnt; eventReady = 1'b0; keySync[1] = 1'b0; keySync[2] = 1'b0;
    step(12); keySync[1] = 1'b1; keySync[2] = 1'b1;
    step(12); keySync[2] = 1'b0;
    step(12);
    chk("t5_held_valid", 32'(eventValid), 1);
    chk("t5_held_key", 32'(eventKey), 1);
    chk("t5_held_type", 32'(eventType), 1);
    push(1, 1, t + 36); push(2, 1, t + 37); push(1, 2, t + 38); push(2, 2, t + 39);
    eventReady = 1'b1;
    step(4);
    chk("t5_drop_count", drop_cnt - drop0, 1);
    chk("t5_valid_low", 32'(eventValid), 0);
    keySync[2] = 1'b1; push(2, 2, t + 53);
    step(16); chk("t5_drained", sb.size(), 0);
    chk("t5_state_off", 32'(keyState), 0);

    // reset with a presented event and one pending
    eventReady = 1'b0; keySync[0] = 1'b0; keySync[1] = 1'b0;
    step(16);
    chk("t6_pre_valid", 32'(eventValid), 1);
    chk("t6_pre_key", 32'(eventKey), 0);
    resetn = 1'b0;
    #2;
    chk("t6_rst_state", 32'(keyState), 0);
    chk("t6_rst_valid", 32'(eventValid), 0);
    chk("t6_rst_key", 32'(eventKey), 0);
    chk("t6_rst_type", 32'(eventType), 0);
    chk("t6_rst_drop", 32'(eventDropped), 0);
    eventReady = 1'b1;
    step(2);
    resetn = 1'b1; t0 = cyc;
    push(1, 1, t0 + 13); push(0, 1, t0 + 14);
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("t6_quiet_valid", 32'(eventValid), 0);
    end
    keySync = 4'b1111;
    push(1, 2, t0 + 25); push(0, 2, t0 + 26);
    step(20);
    chk("t6_drained", sb.size(), 0);
    chk("t6_state_off", 32'(keyState), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
